// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SERIAL_SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit subtraction cells: a half subtractor and the full subtractor
// built from two of them (borrow-out is the OR of both stage borrows).

module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b;
  assign bout = ~a & b;
endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d0, b0, b1;

  half_subtractor u_hs0 (.a(a),  .b(b),   .diff(d0), .bout(b0));
  half_subtractor u_hs1 (.a(d0), .b(bin), .diff(d),  .bout(b1));

  assign bout = b0 | b1;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// Valid/ready on both sides; outputs are registers held until the next result.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sub_state_t       state_q;
  logic [WIDTH-1:0] a_q, b_q;
  // Holds the WIDTH-1 result bits produced so far; the final bit is
  // merged combinationally on the last RUN edge.
  logic [WIDTH-2:0] work_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, b_msb_q, ovf_q;
`endif

  logic             d_bit, br_d;
  logic [WIDTH-1:0] work_full;
  logic [WIDTH-2:0] work_d;

  full_subtractor u_fs (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (br_q),
    .d   (d_bit),
    .bout(br_d)
  );

  assign work_full = {d_bit, work_q};
  assign work_d    = work_full[WIDTH-1:1];

  // Control FSM plus datapath registers, all in one sequential block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            work_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= br_d;
          work_q <= work_d;
          if (cnt_q == CNT_LAST) begin
            diff_q   <= work_full;
            borrow_q <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            // Signed overflow: operand signs differ and result sign differs from a.
            ovf_q    <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags come straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at
// accept time and a negedge monitor compares them on each output handshake.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W+1:0] exp_q[$];   // {overflow, borrow, diff}
  int           acc_q[$];   // accept cycle of each queued operation

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
    int ua, ub, r, sa, sb, sr;
    logic [W-1:0] d;
    logic br, ov;
    ua = int'(av);
    ub = int'(bv);
    r  = ua - ub;
    d  = W'((r + (1 << W)) % (1 << W));
    br = (ua < ub);
    sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
    sr = sa - sb;
    ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return {ov, br, d};
  endfunction

  // Monitor: latency on each rising out_valid, result on each handshake.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) begin
          n_chk++;
          $display("FAIL latency: out_valid with no accepted operation (cycle %0d)", cyc);
        end else begin
          chk("latency", 32'(cyc - acc_q.pop_front()), W);
        end
      end
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious: result %0h with empty scoreboard", diff);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          chk("diff", diff, e[W-1:0]);
          chk("borrow", borrow, e[W]);
`ifdef SERIAL_SUB_OVF_EN
          chk("overflow", overflow, e[W+1]);
`endif
        end
      end
    end
  end

  // Called at posedge+#1; returns after the accept edge (+#1).
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input bit keep, output int acc);
    int t = 0;
    acc = -1;
    in_valid = 1'b1;
    a = av;
    b = bv;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(av, bv));
    acc = cyc + 1;
    acc_q.push_back(acc);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev_acc, t;
    logic [W+1:0] m;
    logic [W-1:0] ops_a[4];
    logic [W-1:0] ops_b[4];

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_overflow", overflow, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the plan.
    send(8'h05, 8'h03, 0, acc); drain();
    send(8'h03, 8'h05, 0, acc); drain();
    send(8'h80, 8'h01, 0, acc); drain();
    send(8'h00, 8'h00, 0, acc); drain();
    send(8'hFF, 8'hFF, 0, acc); drain();
    send(8'h7F, 8'h80, 0, acc); drain();

    // Backpressure: DONE must hold with stable outputs; new operands ignored.
    out_ready = 1'b0;
    m = model(8'hA5, 8'h3C);
    send(8'hA5, 8'h3C, 0, acc);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("bp_reached_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_diff", diff, m[W-1:0]);
      chk("bp_borrow", borrow, m[W]);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of RUN discards the operation.
    send(8'h33, 8'h11, 0, acc);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_borrow", borrow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h10, 8'h01, 0, acc); drain();

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = W'($urandom);
      ops_b[i] = W'($urandom);
    end
    prev_acc = -1;
    for (int i = 0; i < 4; i++) begin
      send(ops_a[i], ops_b[i], 1, acc);
      if (i > 0) chk("b2b_spacing", 32'(acc - prev_acc), W + 2);
      prev_acc = acc;
    end
    in_valid = 1'b0;
    drain();

    // Randomized operands with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i % 5 == 0) ? ra : W'($urandom);
      send(ra, rb, 0, acc);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
